config_fetch_seq: RTL and testbench
===================================

Name: config_fetch_seq

Overview:
- Per-neuron configuration fetch sequencer. Sits directly upstream of the neuron config memory, on its read side.
- On each request for a neuron index, it drives the three config-memory read ports (A: STDP params, B: neuron params, C: per-synapse learn-mode bit).
- It captures the registered read data and packs the NUM_AXONS learn-mode bits into one bitmap.
- It presents the complete neuron config bundle to the neuron controller over a valid/ready handshake.

Parameters:
NUM_NURNS, 256, neurons per core
NUM_AXONS, 256, axons per neuron; number of port-C reads per fetch (>=1)
DSIZE, 16, data width of learning rates, threshold mask, reset potential
NURN_CNT_BIT_WIDTH, 8, neuron index width
AXON_CNT_BIT_WIDTH, 8, axon index width
STDP_WIN_BIT_WIDTH, 8, STDP window width
AER_BIT_WIDTH, 32, spike AER word width

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
req_valid_i  in  1  fetch request valid
req_nurnId_i  in  NURN_CNT_BIT_WIDTH  neuron to fetch
req_ready_o  out  1  sequencer can accept a request
Addr_Config_A_o  out  NURN_CNT_BIT_WIDTH  port A address
rdEn_Config_A_o  out  1  port A read enable
Addr_Config_B_o  out  NURN_CNT_BIT_WIDTH  port B address
rdEn_Config_B_o  out  1  port B read enable
Addr_Config_C_o  out  NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH  port C address {nurnId, axonIdx}
rdEn_Config_C_o  out  1  port C read enable
LTP_Win_i, LTD_Win_i  in  STDP_WIN_BIT_WIDTH each  port A data
LTP_LrnRt_i, LTD_LrnRt_i  in  DSIZE each  port A data
biasLrnMode_i  in  1  port A data
NurnType_i, RandTh_i  in  1 each  port B data
Th_Mask_i, RstPot_i  in  DSIZE each  port B data
SpikeAER_i  in  AER_BIT_WIDTH  port B data
axonLrnMode_i  in  1  port C data
out_valid_o  out  1  config bundle valid
out_ready_i  in  1  consumer accepts bundle
out_nurnId_o  out  NURN_CNT_BIT_WIDTH  neuron index of bundle
out_cfgA_o  out  2*STDP_WIN_BIT_WIDTH+2*DSIZE+1  {LTP_Win, LTD_Win, LTP_LrnRt, LTD_LrnRt, biasLrnMode}
out_cfgB_o  out  2+2*DSIZE+AER_BIT_WIDTH  {NurnType, RandTh, Th_Mask, RstPot, SpikeAER}
out_axonLrnMap_o  out  NUM_AXONS  bit k = learn mode of axon k

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0 except req_ready_o=1.
  - Axon counter 0.
- Memory contract: read data is valid one cycle after rdEn and holds while rdEn is low.
- IDLE:
  - req_ready_o=1.
  - req_valid_i&req_ready_o latches req_nurnId_i, clears the bitmap, sets axon counter k=0, goes to FETCH.
- FETCH, one cycle per axon k=0..NUM_AXONS-1:
  - rdEn_Config_C_o=1, Addr_Config_C_o={nurnId,k}.
  - In k=0 only: rdEn_A/rdEn_B=1, Addr_A=Addr_B=nurnId.
  - Each cycle with k>=1 captures axonLrnMode_i into bitmap bit k-1.
  - The k=1 cycle additionally captures the port A/B fields.
  - After k=NUM_AXONS-1, go to DRAIN.
- DRAIN:
  - No read enables.
  - Captures bit NUM_AXONS-1.
  - If NUM_AXONS==1, captures the A/B fields here.
  - Goes to DONE.
- DONE:
  - out_valid_o=1, bundle stable.
  - Stays in DONE until out_ready_i=1, then returns to IDLE (out_valid_o low next cycle).
- Latency: request handshake at cycle T gives out_valid_o at T+NUM_AXONS+2.
- Address/enable outputs are registered-free combinational decodes of state/counters. They are 0 whenever the matching enable is 0.
- req_ready_o=0 in FETCH/DRAIN/DONE. Requests are not queued; the requester holds req_valid_i.
- Axon counter width is AXON_CNT_BIT_WIDTH. The terminal compare uses NUM_AXONS-1, so no wrap occurs when NUM_AXONS=2^AXON_CNT_BIT_WIDTH.
- Neuron index is not range-checked. Indices >=NUM_NURNS are passed through unmodified.
- out_ready_i outside DONE is ignored.
- Async reset mid-fetch: immediate return to IDLE, all enables low, partial bitmap discarded (zeroed).

Optional Feature:
- Macro CFG_FETCH_PERF_CNT_EN.
- When defined, adds outputs:
  - fetchCnt_o, 16 bits: increments on each out handshake, saturates at 0xFFFF.
  - stallCnt_o, 16 bits: increments each cycle in DONE with out_ready_i=0, saturates.
  - Both reset to 0.
- When undefined, neither port nor its logic exists. Behaviour is otherwise identical.

Test Plan:
- NUM_AXONS=4, request nurnId=2 at T with out_ready_i=1:
  - rdEn_A/B pulse at T+1, addr 2.
  - rdEn_C high T+1..T+4, addresses {2,0}..{2,3}.
  - out_valid_o at T+6 for one cycle.
- Memory C bits for neuron 2 = 1,0,1,1 -> out_axonLrnMap_o=4'b1101. out_cfgB_o equals mem B word 2, e.g. SpikeAER=0x00020005.
- Hold out_ready_i=0 for 5 cycles in DONE:
  - out_valid_o and the bundle stay stable.
  - req_ready_o=0, and a concurrent req_valid_i for nurnId=3 is ignored.
  - Release -> IDLE next cycle, then nurnId=3 is accepted.
- Back-to-back requests for nurnId 0 then 1, with mem A of neuron 1 differing -> the second bundle carries neuron-1 A/B fields and a fresh bitmap, with no leftover bits.
- Assert rst_n_i low at T+3 mid-FETCH -> all outputs 0 and req_ready_o=1 the same cycle. A new request after release completes normally.
- With CFG_FETCH_PERF_CNT_EN: 3 fetches with 2 stall cycles total -> fetchCnt_o=3, stallCnt_o=2. Preload near saturation (force) -> holds at 0xFFFF.

Source files
------------

// File: rtl/config_fetch_seq.sv
// Per-neuron config fetch sequencer: reads ports A/B/C of the neuron config memory and
// hands a packed bundle downstream. Optional perf counters behind CFG_FETCH_PERF_CNT_EN.
module config_fetch_seq #(
   parameter int NUM_NURNS          = 256,
   parameter int NUM_AXONS          = 256,
   parameter int DSIZE              = 16,
   parameter int NURN_CNT_BIT_WIDTH = 8,
   parameter int AXON_CNT_BIT_WIDTH = 8,
   parameter int STDP_WIN_BIT_WIDTH = 8,
   parameter int AER_BIT_WIDTH      = 32
) (
   input  logic                                          clk_i,
   input  logic                                          rst_n_i,
   input  logic                                          req_valid_i,
   input  logic [NURN_CNT_BIT_WIDTH-1:0]                 req_nurnId_i,
   output logic                                          req_ready_o,
   output logic [NURN_CNT_BIT_WIDTH-1:0]                 Addr_Config_A_o,
   output logic                                          rdEn_Config_A_o,
   output logic [NURN_CNT_BIT_WIDTH-1:0]                 Addr_Config_B_o,
   output logic                                          rdEn_Config_B_o,
   output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] Addr_Config_C_o,
   output logic                                          rdEn_Config_C_o,
   input  logic [STDP_WIN_BIT_WIDTH-1:0]                 LTP_Win_i,
   input  logic [STDP_WIN_BIT_WIDTH-1:0]                 LTD_Win_i,
   input  logic [DSIZE-1:0]                              LTP_LrnRt_i,
   input  logic [DSIZE-1:0]                              LTD_LrnRt_i,
   input  logic                                          biasLrnMode_i,
   input  logic                                          NurnType_i,
   input  logic                                          RandTh_i,
   input  logic [DSIZE-1:0]                              Th_Mask_i,
   input  logic [DSIZE-1:0]                              RstPot_i,
   input  logic [AER_BIT_WIDTH-1:0]                      SpikeAER_i,
   input  logic                                          axonLrnMode_i,
   output logic                                          out_valid_o,
   input  logic                                          out_ready_i,
   output logic [NURN_CNT_BIT_WIDTH-1:0]                 out_nurnId_o,
   output logic [2*STDP_WIN_BIT_WIDTH+2*DSIZE:0]         out_cfgA_o,
   output logic [2+2*DSIZE+AER_BIT_WIDTH-1:0]            out_cfgB_o,
`ifdef CFG_FETCH_PERF_CNT_EN
   output logic [NUM_AXONS-1:0]                          out_axonLrnMap_o,
   output logic [15:0]                                   fetchCnt_o,
   output logic [15:0]                                   stallCnt_o
`else
   output logic [NUM_AXONS-1:0]                          out_axonLrnMap_o
`endif
);

   localparam int CFGA_W = 2*STDP_WIN_BIT_WIDTH + 2*DSIZE + 1;
   localparam int CFGB_W = 2 + 2*DSIZE + AER_BIT_WIDTH;
   localparam logic [AXON_CNT_BIT_WIDTH-1:0] LAST_AXON = AXON_CNT_BIT_WIDTH'(NUM_AXONS - 1);
   localparam logic [AXON_CNT_BIT_WIDTH-1:0] AB_AXON   = AXON_CNT_BIT_WIDTH'(1);

   if (NUM_AXONS < 1 || NUM_AXONS > 2**AXON_CNT_BIT_WIDTH ||
       NUM_NURNS < 1 || NUM_NURNS > 2**NURN_CNT_BIT_WIDTH) begin : g_cfg_err
      $error("config_fetch_seq: counter widths too narrow for NUM_AXONS/NUM_NURNS");
   end

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   state_t                          r_state, w_next;
   logic [NURN_CNT_BIT_WIDTH-1:0]   r_nurnId;
   logic [AXON_CNT_BIT_WIDTH-1:0]   r_axonCnt;
   logic [NUM_AXONS-1:0]            r_map;
   logic [CFGA_W-1:0]               r_cfgA;
   logic [CFGB_W-1:0]               r_cfgB;
   logic                            w_accept, w_capBit, w_capAB;
   logic [AXON_CNT_BIT_WIDTH-1:0]   w_bitIdx;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Read data lags its enable by one cycle, so axon k's bit lands while k+1 is addressed.
   always_comb begin
      w_next          = r_state;
      req_ready_o     = 1'b0;
      rdEn_Config_A_o = 1'b0;
      rdEn_Config_B_o = 1'b0;
      rdEn_Config_C_o = 1'b0;
      Addr_Config_A_o = '0;
      Addr_Config_B_o = '0;
      Addr_Config_C_o = '0;
      out_valid_o     = 1'b0;
      w_accept        = 1'b0;
      w_capBit        = 1'b0;
      w_capAB         = 1'b0;
      w_bitIdx        = '0;
      case (r_state)
         S_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               w_accept = 1'b1;
               w_next   = S_FETCH;
            end
         end
         S_FETCH: begin
            rdEn_Config_C_o = 1'b1;
            Addr_Config_C_o = {r_nurnId, r_axonCnt};
            if (r_axonCnt == '0) begin
               rdEn_Config_A_o = 1'b1;
               rdEn_Config_B_o = 1'b1;
               Addr_Config_A_o = r_nurnId;
               Addr_Config_B_o = r_nurnId;
            end else begin
               w_capBit = 1'b1;
               w_bitIdx = r_axonCnt - 1'b1;
            end
            w_capAB = (r_axonCnt == AB_AXON);
            if (r_axonCnt == LAST_AXON) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            w_capBit = 1'b1;
            w_bitIdx = LAST_AXON;
            w_capAB  = (NUM_AXONS == 1);
            w_next   = S_DONE;
         end
         default: begin
            out_valid_o = 1'b1;
            if (out_ready_i) w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_nurnId  <= '0;
         r_axonCnt <= '0;
         r_map     <= '0;
         r_cfgA    <= '0;
         r_cfgB    <= '0;
      end else begin
         if (w_accept) begin
            r_nurnId  <= req_nurnId_i;
            r_axonCnt <= '0;
            r_map     <= '0;
         end else if (r_state == S_FETCH && r_axonCnt != LAST_AXON) begin
            r_axonCnt <= r_axonCnt + 1'b1;
         end
         if (w_capBit) begin
            for (int i = 0; i < NUM_AXONS; i++) begin
               if (w_bitIdx == AXON_CNT_BIT_WIDTH'(i)) r_map[i] <= axonLrnMode_i;
            end
         end
         if (w_capAB) begin
            r_cfgA <= {LTP_Win_i, LTD_Win_i, LTP_LrnRt_i, LTD_LrnRt_i, biasLrnMode_i};
            r_cfgB <= {NurnType_i, RandTh_i, Th_Mask_i, RstPot_i, SpikeAER_i};
         end
      end
   end

   assign out_nurnId_o     = r_nurnId;
   assign out_cfgA_o       = r_cfgA;
   assign out_cfgB_o       = r_cfgB;
   assign out_axonLrnMap_o = r_map;

`ifdef CFG_FETCH_PERF_CNT_EN
   logic [15:0] r_fetchCnt, r_stallCnt;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_fetchCnt <= '0;
         r_stallCnt <= '0;
      end else begin
         if (out_valid_o && out_ready_i && r_fetchCnt != 16'hFFFF)
            r_fetchCnt <= r_fetchCnt + 16'd1;
         if (out_valid_o && !out_ready_i && r_stallCnt != 16'hFFFF)
            r_stallCnt <= r_stallCnt + 16'd1;
      end
   end

   assign fetchCnt_o = r_fetchCnt;
   assign stallCnt_o = r_stallCnt;
`endif

endmodule

// File: tb/tb_config_fetch_seq.sv
// Directed + randomized bench for config_fetch_seq against a memory-image reference model.
module tb_config_fetch_seq;
   localparam int NN   = 200;
   localparam int NA   = 4;
   localparam int NW   = 8;
   localparam int AW   = 8;
   localparam int DS   = 16;
   localparam int SW   = 8;
   localparam int AERW = 32;
   localparam int CA_W = 2*SW + 2*DS + 1;
   localparam int CB_W = 2 + 2*DS + AERW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req_valid = 1'b0;
   logic [NW-1:0] req_nurnId = '0;
   logic req_ready;
   logic [NW-1:0] addrA, addrB;
   logic [NW+AW-1:0] addrC;
   logic rdA, rdB, rdC;
   logic out_valid;
   logic out_ready = 1'b0;
   logic [NW-1:0] out_nurnId;
   logic [CA_W-1:0] out_cfgA;
   logic [CB_W-1:0] out_cfgB;
   logic [NA-1:0] out_map;
`ifdef CFG_FETCH_PERF_CNT_EN
   logic [15:0] fetchCnt, stallCnt;
   int exp_fetch = 0;
   int exp_stall = 0;
`endif

   logic [CA_W-1:0] memA [256];
   logic [CB_W-1:0] memB [256];
   logic            memC [256][256];
   logic [CA_W-1:0] dA = '0;
   logic [CB_W-1:0] dB = '0;
   logic            dC = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Registered-read memory: data appears one cycle after enable and holds otherwise.
   always @(posedge clk) begin
      if (rdA) dA <= memA[addrA];
      if (rdB) dB <= memB[addrB];
      if (rdC) dC <= memC[addrC[NW+AW-1:AW]][addrC[AW-1:0]];
   end

   config_fetch_seq #(
      .NUM_NURNS(NN), .NUM_AXONS(NA), .DSIZE(DS), .NURN_CNT_BIT_WIDTH(NW),
      .AXON_CNT_BIT_WIDTH(AW), .STDP_WIN_BIT_WIDTH(SW), .AER_BIT_WIDTH(AERW)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_valid_i(req_valid), .req_nurnId_i(req_nurnId), .req_ready_o(req_ready),
      .Addr_Config_A_o(addrA), .rdEn_Config_A_o(rdA),
      .Addr_Config_B_o(addrB), .rdEn_Config_B_o(rdB),
      .Addr_Config_C_o(addrC), .rdEn_Config_C_o(rdC),
      .LTP_Win_i(dA[48:41]), .LTD_Win_i(dA[40:33]), .LTP_LrnRt_i(dA[32:17]),
      .LTD_LrnRt_i(dA[16:1]), .biasLrnMode_i(dA[0]),
      .NurnType_i(dB[65]), .RandTh_i(dB[64]), .Th_Mask_i(dB[63:48]), .RstPot_i(dB[47:32]),
      .SpikeAER_i(dB[31:0]), .axonLrnMode_i(dC),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_nurnId_o(out_nurnId),
      .out_cfgA_o(out_cfgA), .out_cfgB_o(out_cfgB),
`ifdef CFG_FETCH_PERF_CNT_EN
      .out_axonLrnMap_o(out_map), .fetchCnt_o(fetchCnt), .stallCnt_o(stallCnt)
`else
      .out_axonLrnMap_o(out_map)
`endif
   );

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NA-1:0] exp_map(input int n);
      logic [NA-1:0] m;
      for (int k = 0; k < NA; k++) m[k] = memC[n][k];
      return m;
   endfunction

   task automatic chk_bundle(input string tag, input int n);
      chk({tag, "_valid"}, 128'(out_valid), 128'(1));
      chk({tag, "_id"},    128'(out_nurnId), 128'(n));
      chk({tag, "_cfgA"},  128'(out_cfgA), 128'(memA[n]));
      chk({tag, "_cfgB"},  128'(out_cfgB), 128'(memB[n]));
      chk({tag, "_map"},   128'(out_map), 128'(exp_map(n)));
      chk({tag, "_rdy"},   128'(req_ready), 128'(0));
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_rdy"},   128'(req_ready), 128'(1));
      chk({tag, "_vld"},   128'(out_valid), 128'(0));
      chk({tag, "_en"},    128'({rdA, rdB, rdC}), 128'(0));
      chk({tag, "_addr"},  128'({addrA, addrB, addrC}), 128'(0));
   endtask

   // Full request-to-handshake transaction; alt >= 0 raises a competing request while stalled.
   task automatic do_fetch(input int n, input int hold, input int alt);
      req_valid  = 1'b1;
      req_nurnId = NW'(n);
      chk("req_ready_idle", 128'(req_ready), 128'(1));
      out_ready  = 1'($urandom_range(0, 1));
      cyc();
      req_valid = 1'b0;
      chk("k0_enAB",   128'({rdA, rdB}), 128'(2'b11));
      chk("k0_addrAB", 128'({addrA, addrB}), 128'({NW'(n), NW'(n)}));
      chk("k0_enC",    128'(rdC), 128'(1));
      chk("k0_addrC",  128'(addrC), 128'({NW'(n), AW'(0)}));
      chk("k0_rdy",    128'(req_ready), 128'(0));
      for (int k = 1; k < NA; k++) begin
         out_ready = 1'($urandom_range(0, 1));
         cyc();
         chk("kN_enAB",  128'({rdA, rdB, addrA, addrB}), 128'(0));
         chk("kN_addrC", 128'({rdC, addrC}), 128'({1'b1, NW'(n), AW'(k)}));
         chk("kN_vld",   128'(out_valid), 128'(0));
      end
      cyc();
      chk("drain_en",  128'({rdA, rdB, rdC, addrC}), 128'(0));
      chk("drain_vld", 128'(out_valid), 128'(0));
      cyc();
      chk_bundle("done", n);
      for (int h = 0; h < hold; h++) begin
         out_ready = 1'b0;
         if (alt >= 0) begin
            req_valid  = 1'b1;
            req_nurnId = NW'(alt);
         end
         cyc();
         chk_bundle("stall", n);
      end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk("post_vld", 128'(out_valid), 128'(0));
      chk("post_rdy", 128'(req_ready), 128'(1));
`ifdef CFG_FETCH_PERF_CNT_EN
      exp_fetch++;
      exp_stall += hold;
      chk("fetchCnt", 128'(fetchCnt), 128'(exp_fetch));
      chk("stallCnt", 128'(stallCnt), 128'(exp_stall));
`endif
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         memA[i] = CA_W'({$urandom(), $urandom()});
         memB[i] = CB_W'({$urandom(), $urandom(), $urandom()});
         for (int k = 0; k < 256; k++) memC[i][k] = 1'($urandom_range(0, 1));
      end
      memC[2][0] = 1'b1; memC[2][1] = 1'b0; memC[2][2] = 1'b1; memC[2][3] = 1'b1;
      memB[2][31:0] = 32'h0002_0005;
      for (int k = 0; k < NA; k++) memC[0][k] = 1'b1;
      for (int k = 0; k < NA; k++) memC[1][k] = (k == 1);
      memA[1] = ~memA[0];
      memB[1] = ~memB[0];

      // Reset state
      cyc();
      chk_idle_outputs("rst");
      chk("rst_bundle", 128'({out_nurnId, out_cfgA, out_map}), 128'(0));
      chk("rst_cfgB", 128'(out_cfgB), 128'(0));
      cyc();
      rst_n = 1'b1;
      cyc();
      chk_idle_outputs("idle");

      // Known neuron-2 image
      do_fetch(2, 0, -1);
      chk("map_n2", 128'(exp_map(2)), 128'(4'b1101));

      // Stall 5 cycles with a competing request for neuron 3, then serve it
      do_fetch(2, 5, 3);
      chk("alt_pending", 128'({req_valid, req_nurnId}), 128'({1'b1, NW'(3)}));
      do_fetch(3, 0, -1);

      // Back-to-back: no leftover bits from the all-ones bitmap of neuron 0
      do_fetch(0, 0, -1);
      do_fetch(1, 0, -1);
      chk("b2b_map", 128'(out_map), 128'(4'b0010));

      // Index beyond NUM_NURNS passes straight through
      do_fetch(250, 1, -1);

      // Asynchronous reset three cycles into a fetch
      req_valid  = 1'b1;
      req_nurnId = NW'(7);
      cyc();
      req_valid = 1'b0;
      cyc();
      cyc();
      chk("pre_rst_enC", 128'(rdC), 128'(1));
      rst_n = 1'b0;
      #1;
      chk_idle_outputs("midrst");
      chk("midrst_map", 128'({out_map, out_nurnId}), 128'(0));
`ifdef CFG_FETCH_PERF_CNT_EN
      exp_fetch = 0;
      exp_stall = 0;
`endif
      cyc();
      rst_n = 1'b1;
      cyc();
      do_fetch(9, 2, -1);

      // Randomized traffic
      for (int t = 0; t < 20; t++) begin
         do_fetch(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) : -1);
         req_valid = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
